// File: rtl/dmem_bytelane.sv
// Byte-addressed data memory with lane enables, 1-cycle registered loads,
// misalignment/range error reporting and an optional post-reset clear sweep.
module dmem_bytelane #(
  parameter int ADDR_W     = 12,
  parameter int DEPTH      = 1024,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       st_data_i,
  output logic              ready_o,
  output logic              ld_valid_o,
  output logic [31:0]       ld_data_o,
  output logic              err_o
);

  localparam int               IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  LIMIT = (ADDR_W+1)'(4 * DEPTH);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(DEPTH - 1);

  // state  | meaning
  // S_INIT | clear sweep, writes 0 to word cnt each cycle
  // S_RUN  | accepting one access per cycle
  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] cnt;
  logic [31:0]      mem [DEPTH];

  logic             ready, clr_we, accept, err, st_we;
  logic [1:0]       lane;
  logic [IDX_W-1:0] idx;
  logic [3:0]       be;
  logic [31:0]      wdata, rd_word, ld_ext;
  logic [7:0]       sel_b;
  logic [15:0]      sel_h;
  logic             ld_valid_q, err_q;
  logic [31:0]      ld_data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= INIT_CLEAR ? S_INIT : S_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (clr_we) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == S_INIT && cnt == LAST) state_nxt = S_RUN;
  end

  always_comb begin
    ready  = (state == S_RUN) && !rst_i;
    clr_we = (state == S_INIT) && !rst_i;
  end

  assign ready_o = ready;

  always_comb begin
    lane = addr_i[1:0];
    idx  = addr_i[IDX_W+1:2];
    case (size_i)
      2'b00:   err = 1'b0;
      2'b01:   err = addr_i[0];
      2'b10:   err = |addr_i[1:0];
      default: err = 1'b1;
    endcase
    if ({1'b0, addr_i} >= LIMIT) err = 1'b1;
    accept = req_i & ready;
    st_we  = accept & we_i & ~err;
  end

  // Store data is replicated into every lane; the byte enables pick the live ones.
  always_comb begin
    case (size_i)
      2'b00:   begin be = 4'b0001 << lane; wdata = {4{st_data_i[7:0]}};  end
      2'b01:   begin be = 4'b0011 << lane; wdata = {2{st_data_i[15:0]}}; end
      default: begin be = 4'b1111;         wdata = st_data_i;            end
    endcase
  end

  always_comb begin
    rd_word = mem[idx];
    sel_b   = rd_word[8*lane +: 8];
    sel_h   = rd_word[16*lane[1] +: 16];
    case (size_i)
      2'b00:   ld_ext = {{24{~unsigned_i & sel_b[7]}}, sel_b};
      2'b01:   ld_ext = {{16{~unsigned_i & sel_h[15]}}, sel_h};
      default: ld_ext = rd_word;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (clr_we) begin
      mem[cnt] <= '0;
    end else if (st_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Load data only moves on a completed load, so it holds across stores and idle cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ld_valid_q <= 1'b0;
      err_q      <= 1'b0;
      ld_data_q  <= '0;
    end else begin
      ld_valid_q <= accept & ~we_i;
      err_q      <= accept & err;
      if (accept && !we_i) ld_data_q <= err ? 32'h0 : ld_ext;
    end
  end

  assign ld_valid_o = ld_valid_q;
  assign err_o      = err_q;
  assign ld_data_o  = ld_data_q;

endmodule

// File: tb/tb_dmem_bytelane.sv
// Directed bench for dmem_bytelane: reset sweep, lane stores, extended loads,
// error cases, store-to-load forwarding and reset during the sweep.
module tb_dmem_bytelane;

  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [1:0]    size = 2'b10;
  logic          uns = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [31:0]   st_data = '0;
  logic          ready, ld_valid, err;
  logic [31:0]   ld_data;

  int n_pass = 0;
  int n_total = 0;
  int n;

  dmem_bytelane #(.ADDR_W(AW), .DEPTH(1024), .INIT_CLEAR(1'b1)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .we_i       (we),
    .size_i     (size),
    .unsigned_i (uns),
    .addr_i     (addr),
    .st_data_i  (st_data),
    .ready_o    (ready),
    .ld_valid_o (ld_valid),
    .ld_data_o  (ld_data),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input logic w, input logic [1:0] s, input logic u,
                       input logic [AW-1:0] a, input logic [31:0] d);
    req = 1'b1; we = w; size = s; uns = u; addr = a; st_data = d;
  endtask

  // One accepted access; returns #1 after the accepting edge with req dropped.
  task automatic acc(input logic w, input logic [1:0] s, input logic u,
                     input logic [AW-1:0] a, input logic [31:0] d);
    drive(w, s, u, a, d);
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic chk_ld(input string tag, input logic [31:0] exp_d, input logic exp_e);
    chk({tag, "_valid"}, {31'b0, ld_valid}, 32'd1);
    chk({tag, "_data"}, ld_data, exp_d);
    chk({tag, "_err"}, {31'b0, err}, {31'b0, exp_e});
  endtask

  task automatic wait_ready(input string tag);
    n = 0;
    while (!ready && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, n, 1024);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_valid", {31'b0, ld_valid}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_data", ld_data, 32'h0);

    // Load request during the sweep must be ignored.
    rst = 1'b0;
    drive(1'b0, 2'b10, 1'b0, 13'h010, 32'h0);
    @(posedge clk); #1;
    chk("init_ign_valid", {31'b0, ld_valid}, 32'd0);
    chk("init_ign_ready", {31'b0, ready}, 32'd0);
    req = 1'b0;
    n = 1;
    while (!ready && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("sweep_len", n, 1024);

    acc(1'b0, 2'b10, 1'b0, 13'h000, 32'h0);
    chk_ld("clr_w0", 32'h0, 1'b0);
    acc(1'b0, 2'b10, 1'b0, 13'hFFC, 32'h0);
    chk_ld("clr_wlast", 32'h0, 1'b0);
    @(posedge clk); #1;
    chk("valid_pulse", {31'b0, ld_valid}, 32'd0);

    acc(1'b1, 2'b10, 1'b0, 13'h010, 32'h11223344);
    chk("sw_valid", {31'b0, ld_valid}, 32'd0);
    chk("sw_err", {31'b0, err}, 32'd0);
    acc(1'b1, 2'b00, 1'b0, 13'h012, 32'h123456AA);
    acc(1'b0, 2'b10, 1'b0, 13'h010, 32'h0);
    chk_ld("lw_10", 32'h11AA3344, 1'b0);
    acc(1'b0, 2'b00, 1'b1, 13'h012, 32'h0);
    chk_ld("lbu_12", 32'h000000AA, 1'b0);
    acc(1'b0, 2'b00, 1'b0, 13'h012, 32'h0);
    chk_ld("lb_12", 32'hFFFFFFAA, 1'b0);
    acc(1'b0, 2'b00, 1'b0, 13'h013, 32'h0);
    chk_ld("lb_13", 32'h00000011, 1'b0);

    acc(1'b1, 2'b10, 1'b0, 13'h020, 32'hCAFE5678);
    acc(1'b1, 2'b01, 1'b0, 13'h022, 32'h77778001);
    acc(1'b0, 2'b01, 1'b0, 13'h022, 32'h0);
    chk_ld("lh_22", 32'hFFFF8001, 1'b0);
    acc(1'b0, 2'b01, 1'b1, 13'h022, 32'h0);
    chk_ld("lhu_22", 32'h00008001, 1'b0);
    acc(1'b0, 2'b01, 1'b0, 13'h020, 32'h0);
    chk_ld("lh_20", 32'h00005678, 1'b0);
    acc(1'b0, 2'b10, 1'b0, 13'h020, 32'h0);
    chk_ld("lw_20", 32'h80015678, 1'b0);

    acc(1'b0, 2'b10, 1'b0, 13'h013, 32'h0);
    chk_ld("err_lw13", 32'h0, 1'b1);
    acc(1'b0, 2'b01, 1'b0, 13'h011, 32'h0);
    chk_ld("err_lh11", 32'h0, 1'b1);
    acc(1'b0, 2'b11, 1'b0, 13'h010, 32'h0);
    chk_ld("err_size3", 32'h0, 1'b1);
    acc(1'b0, 2'b10, 1'b0, 13'h1000, 32'h0);
    chk_ld("err_range", 32'h0, 1'b1);
    acc(1'b1, 2'b10, 1'b0, 13'h012, 32'hFFFFFFFF);
    chk("err_sw_err", {31'b0, err}, 32'd1);
    chk("err_sw_valid", {31'b0, ld_valid}, 32'd0);
    acc(1'b1, 2'b10, 1'b0, 13'h1000, 32'hFFFFFFFF);
    chk("err_swr_err", {31'b0, err}, 32'd1);
    @(posedge clk); #1;
    chk("err_pulse", {31'b0, err}, 32'd0);
    acc(1'b0, 2'b10, 1'b0, 13'h010, 32'h0);
    chk_ld("unch_10", 32'h11AA3344, 1'b0);
    acc(1'b0, 2'b10, 1'b0, 13'h000, 32'h0);
    chk_ld("nowrap_0", 32'h0, 1'b0);

    // Store then load the same word on consecutive cycles.
    drive(1'b1, 2'b10, 1'b0, 13'h040, 32'hDEADBEEF);
    @(posedge clk); #1;
    chk("b2b_st_valid", {31'b0, ld_valid}, 32'd0);
    drive(1'b0, 2'b10, 1'b0, 13'h040, 32'h0);
    @(posedge clk); #1;
    drive(1'b0, 2'b10, 1'b0, 13'h010, 32'h0);
    chk_ld("b2b_ld40", 32'hDEADBEEF, 1'b0);
    @(posedge clk); #1;
    req = 1'b0;
    chk_ld("b2b_ld10", 32'h11AA3344, 1'b0);
    acc(1'b1, 2'b10, 1'b0, 13'h044, 32'h01020304);
    chk("hold_data", ld_data, 32'h11AA3344);

    // Reset in the middle of the sweep restarts it.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (500) @(posedge clk);
    #1;
    chk("mid_ready", {31'b0, ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("r6_ready", {31'b0, ready}, 32'd0);
    chk("r6_data", ld_data, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_ready("resweep_len");
    acc(1'b0, 2'b10, 1'b0, 13'h010, 32'h0);
    chk_ld("reclr_10", 32'h0, 1'b0);
    acc(1'b0, 2'b10, 1'b0, 13'h040, 32'h0);
    chk_ld("reclr_40", 32'h0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
